// File: rtl/baseerat_delay_line_if.sv
// Bundle of data-path, control and status signals for the programmable delay line.
// The master side drives stimulus and reads status; the slave side is the delay line.
interface baseerat_delay_line_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_STAGES = 8
);
  localparam int LAT_W = $clog2(MAX_STAGES + 1);

  logic                  en;
  logic                  flush;
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic [LAT_W-1:0]      lat_sel;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic [LAT_W-1:0]      occupancy;
  logic [LAT_W-1:0]      lat_cur;
  logic                  lat_pending;

  modport master (
    output en, flush, din_valid, din, lat_sel,
    input  dout, dout_valid, occupancy, lat_cur, lat_pending
  );

  modport slave (
    input  en, flush, din_valid, din, lat_sel,
    output dout, dout_valid, occupancy, lat_cur, lat_pending
  );
endinterface

// File: rtl/baseerat_delay_line.sv
// Fixed-depth shift pipeline with a run-time selectable tap (latency).
// The tap only moves while the active stages are empty, so no word is lost or repeated.
module baseerat_delay_line #(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_STAGES  = 8,
  parameter int DEFAULT_LAT = 4
) (
  input logic                  clk,
  input logic                  reset,
  baseerat_delay_line_if.slave bus
);
  localparam int LAT_W = $clog2(MAX_STAGES + 1);
  localparam int LP_RST_LAT_I = (DEFAULT_LAT < 1) ? 1 :
                                ((DEFAULT_LAT > MAX_STAGES) ? MAX_STAGES : DEFAULT_LAT);
  localparam logic [LAT_W-1:0] LP_RST_LAT = LAT_W'(LP_RST_LAT_I);

  logic [MAX_STAGES:1][DATA_WIDTH-1:0] r_data;
  logic [MAX_STAGES:1]                 r_vld;
  logic [LAT_W-1:0]                    r_lat_cur;

  logic [LAT_W-1:0]      w_lat_eff;
  logic [LAT_W-1:0]      w_occ;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_dout_vld;

  always_comb begin
    if (bus.lat_sel == '0)
      w_lat_eff = LAT_W'(1);
    else if (bus.lat_sel > LAT_W'(MAX_STAGES))
      w_lat_eff = LAT_W'(MAX_STAGES);
    else
      w_lat_eff = bus.lat_sel;
  end

  always_comb begin
    w_occ      = '0;
    w_dout     = '0;
    w_dout_vld = 1'b0;
    for (int k = 1; k <= MAX_STAGES; k++) begin
      if (k <= int'(r_lat_cur))
        w_occ = w_occ + LAT_W'(r_vld[k]);
      if (k == int'(r_lat_cur)) begin
        w_dout     = r_data[k];
        w_dout_vld = r_vld[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_vld     <= '0;
      r_lat_cur <= LP_RST_LAT;
    end else begin
      if (w_occ == '0)
        r_lat_cur <= w_lat_eff;
      if (bus.flush) begin
        r_vld <= '0;
      end else if (bus.en) begin
        r_vld[1] <= bus.din_valid;
        if (bus.din_valid)
          r_data[1] <= bus.din;
        // Data keeps shifting past the tap, but valids die there so a later
        // latency increase cannot resurrect words that already left.
        for (int k = 2; k <= MAX_STAGES; k++) begin
          r_data[k] <= r_data[k-1];
          r_vld[k]  <= r_vld[k-1] && (k <= int'(r_lat_cur));
        end
      end
    end
  end

  assign bus.dout        = w_dout;
  assign bus.dout_valid  = w_dout_vld;
  assign bus.occupancy   = w_occ;
  assign bus.lat_cur     = r_lat_cur;
  assign bus.lat_pending = (w_lat_eff != r_lat_cur);
endmodule

// File: tb/tb_baseerat_delay_line.sv
// Scoreboard bench for baseerat_delay_line: directed scenarios plus random traffic,
// checked against an age-based model of in-flight words.
module tb_baseerat_delay_line;
  localparam int DW = 16;
  localparam int MS = 8;
  localparam int DL = 4;
  localparam int LW = $clog2(MS + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  baseerat_delay_line_if #(.DATA_WIDTH(DW), .MAX_STAGES(MS)) bus ();

  baseerat_delay_line #(.DATA_WIDTH(DW), .MAX_STAGES(MS), .DEFAULT_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            age;
  } item_t;

  item_t q[$];
  int    lat_m       = DL;
  int    occ_at_edge = 0;
  bit    clean       = 1'b1;
  bit    ev;
  int    n_chk       = 0;
  int    n_pass      = 0;
  int    max_occ     = 0;

  function automatic int clampf(int s);
    if (s < 1) return 1;
    if (s > MS) return MS;
    return s;
  endfunction

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Reference model: each in-flight word carries its age in enabled edges.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      lat_m = clampf(DL);
      clean = 1'b1;
    end else begin
      if (occ_at_edge == 0) lat_m = clampf(int'(bus.lat_sel));
      if (bus.flush) begin
        q.delete();
      end else if (bus.en) begin
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (bus.din_valid) begin
          q.push_back('{bus.din, 1});
          clean = 1'b0;
        end
      end
    end
  end

  // Monitor: compares outputs away from the active edge and retires words.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_dout_valid", bus.dout_valid, 0);
      chk("rst_occupancy", bus.occupancy, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_lat_cur", bus.lat_cur, clampf(DL));
      occ_at_edge = 0;
    end else begin
      ev = (q.size() > 0) && (q[0].age == lat_m);
      chk("dout_valid", bus.dout_valid, ev);
      chk("occupancy", bus.occupancy, q.size());
      chk("lat_cur", bus.lat_cur, lat_m);
      chk("lat_pending", bus.lat_pending, clampf(int'(bus.lat_sel)) != lat_m);
      if (clean) chk("dout_idle_zero", bus.dout, 0);
      if (ev && bus.dout_valid) chk("dout", bus.dout, q[0].data);
      if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
      occ_at_edge = q.size();
      if (ev && (bus.en || bus.flush)) void'(q.pop_front());
    end
  end

  task automatic drive(bit e, bit f, bit dv, logic [DW-1:0] d, int ls);
    @(posedge clk);
    #1;
    bus.en        = e;
    bus.flush     = f;
    bus.din_valid = dv;
    bus.din       = d;
    bus.lat_sel   = LW'(ls);
  endtask

  initial begin
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.flush     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.lat_sel   = LW'(4);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // latency 4 stream
    max_occ = 0;
    for (int i = 0; i < 8; i++) drive(1, 0, 1, DW'(16'h00A1 + i), 4);
    repeat (8) drive(1, 0, 0, '0, 4);
    chk("peak_occupancy", max_occ, 4);

    // stall at latency 3
    repeat (2) drive(1, 0, 0, '0, 3);
    drive(1, 0, 1, 16'h0011, 3);
    drive(1, 0, 1, 16'h0022, 3);
    repeat (5) drive(0, 0, 0, '0, 3);
    repeat (6) drive(1, 0, 0, '0, 3);

    // latency change waits for drain
    drive(1, 0, 1, 16'h0101, 3);
    drive(1, 0, 1, 16'h0202, 3);
    drive(1, 0, 0, '0, 6);
    #1;
    chk("pending_while_busy", bus.lat_pending, 1);
    chk("lat_hold_while_busy", bus.lat_cur, 3);
    repeat (4) drive(1, 0, 0, '0, 6);
    chk("lat_after_drain", bus.lat_cur, 6);
    drive(1, 0, 1, 16'h0BEE, 6);
    repeat (8) drive(1, 0, 0, '0, 6);

    // clamping
    drive(1, 0, 0, '0, 0);
    drive(1, 0, 0, '0, 0);
    #1 chk("clamp_low", bus.lat_cur, 1);
    drive(1, 0, 1, 16'h5A5A, 0);
    repeat (2) drive(1, 0, 0, '0, 0);
    repeat (3) drive(1, 0, 0, '0, 15);
    #1 chk("clamp_high", bus.lat_cur, 8);

    // flush with words in flight at latency 5
    repeat (2) drive(1, 0, 0, '0, 5);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, DW'(16'h0C01 + i), 5);
    drive(1, 1, 1, 16'hDEAD, 5);
    drive(1, 0, 0, '0, 5);
    #1;
    chk("flush_occupancy", bus.occupancy, 0);
    chk("flush_dout_valid", bus.dout_valid, 0);
    repeat (8) drive(1, 0, 0, '0, 5);

    // reset mid-stream with a pending latency request
    repeat (2) drive(1, 0, 0, '0, 4);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, DW'(16'h0D01 + i), 4);
    drive(0, 0, 0, '0, 2);
    #1;
    chk("pre_reset_occupancy", bus.occupancy, 3);
    reset = 1'b1;
    #1;
    chk("async_rst_dout_valid", bus.dout_valid, 0);
    chk("async_rst_occupancy", bus.occupancy, 0);
    chk("async_rst_dout", bus.dout, 0);
    chk("async_rst_lat_cur", bus.lat_cur, 4);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drive(1, 0, 0, '0, 2);
    #1 chk("lat_after_reset", bus.lat_cur, 2);
    repeat (4) drive(1, 0, 0, '0, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 7, DW'($urandom), int'($urandom_range(0, 15)));
    repeat (80) drive(1, 0, 0, '0, 3);
    chk("final_occupancy", bus.occupancy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
